key_entry_ctrl: RTL and testbench

Sequencer between the matrix-keypad scanner and the hex-to-decimal conversion/display path of the keypad project. It collects up to three decimal digit keys, supports clear, backspace and enter, checks the result against the 9-bit range, and issues one validated value with a single-cycle valid pulse per committed entry. It also exposes the in-progress digits for the display path.

---
 rtl/key_entry_ctrl.sv | 161 ++++++++++++++++
 tb/tb_key_entry_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: collects up to three decimal digits from the keypad scanner,
// handles clear/backspace/enter, range-checks the entry against 9 bits and
// issues a committed value with a single-cycle valid pulse.
// Optional feature: define KEY_TIMEOUT_EN to auto-clear an idle entry after
// TIMEOUT_CYC cycles without a key.
module key_entry_ctrl #(
  parameter int unsigned MAX_DIGITS  = 3,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_num,
  input  logic        key_vld,
  output logic [8:0]  dout,
  output logic        dout_vld,
  output logic [11:0] disp_bcd,
  output logic [1:0]  disp_cnt,
  output logic        err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENTRY  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [1:0] DIG_FULL  = 2'(MAX_DIGITS);

  localparam logic [3:0] KEY_CLR   = 4'hA;
  localparam logic [3:0] KEY_BS    = 4'hB;
  localparam logic [3:0] KEY_ENT   = 4'hE;

  logic [1:0]  r_state, w_state_nx;
  logic [11:0] r_bcd, w_bcd_nx;
  logic [1:0]  r_cnt, w_cnt_nx;
  logic [8:0]  r_dout, w_dout_nx;
  logic        r_vld, w_vld_nx;
  logic        r_err, w_err_nx;
  logic        w_digit;
  logic [9:0]  w_value;
  logic        w_timeout;

  assign w_digit = key_vld && (key_num < 4'hA);

  // Decimal value of the held digits; upper nibbles are zero for short entries
  assign w_value = 10'(r_bcd[11:8]) * 10'd100 + 10'(r_bcd[7:4]) * 10'd10
                 + 10'(r_bcd[3:0]);

`ifdef KEY_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_run;

  assign w_to_run  = (r_state == ST_ENTRY) || (r_state == ST_ERR);
  // A key in the same cycle as expiry wins, so the timeout is masked by key_vld
  assign w_timeout = w_to_run && !key_vld && (r_to_cnt == TO_LAST);

  // Idle-cycle counter: restarts on any key, runs only while an entry is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (key_vld || !w_to_run || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and datapath decode for each key in each state
  always_comb begin
    w_state_nx = r_state;
    w_bcd_nx   = r_bcd;
    w_cnt_nx   = r_cnt;
    w_dout_nx  = r_dout;
    w_err_nx   = r_err;
    w_vld_nx   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_digit) begin
          w_bcd_nx   = {8'h00, key_num};
          w_cnt_nx   = 2'd1;
          w_state_nx = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (w_digit) begin
          if (r_cnt < DIG_FULL) begin
            w_bcd_nx = {r_bcd[7:0], key_num};
            w_cnt_nx = r_cnt + 2'd1;
          end
        end else if (key_vld && key_num == KEY_BS) begin
          w_bcd_nx = {4'h0, r_bcd[11:4]};
          w_cnt_nx = r_cnt - 2'd1;
          if (r_cnt == 2'd1) w_state_nx = ST_IDLE;
        end else if (key_vld && key_num == KEY_CLR) begin
          w_bcd_nx   = '0;
          w_cnt_nx   = '0;
          w_state_nx = ST_IDLE;
        end else if (key_vld && key_num == KEY_ENT) begin
          w_state_nx = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (w_value <= 10'd511) begin
          w_dout_nx  = w_value[8:0];
          w_vld_nx   = 1'b1;
          w_bcd_nx   = '0;
          w_cnt_nx   = '0;
          w_state_nx = ST_IDLE;
        end else begin
          w_err_nx   = 1'b1;
          w_state_nx = ST_ERR;
        end
      end
      default: begin
        if (key_vld && key_num == KEY_CLR) begin
          w_err_nx   = 1'b0;
          w_bcd_nx   = '0;
          w_cnt_nx   = '0;
          w_state_nx = ST_IDLE;
        end
      end
    endcase
    if (w_timeout) begin
      w_err_nx   = 1'b0;
      w_bcd_nx   = '0;
      w_cnt_nx   = '0;
      w_state_nx = ST_IDLE;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_bcd   <= w_bcd_nx;
      r_cnt   <= w_cnt_nx;
      r_dout  <= w_dout_nx;
      r_vld   <= w_vld_nx;
      r_err   <= w_err_nx;
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_vld;
  assign disp_bcd = r_bcd;
  assign disp_cnt = r_cnt;
  assign err      = r_err;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Scoreboard bench for key_entry_ctrl: stimulus pushes expected commits
// (value and the cycle the pulse must appear in); a monitor pops on dout_vld.
module tb_key_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_num = 4'h0;
  logic        key_vld = 1'b0;
  logic [8:0]  dout;
  logic        dout_vld;
  logic [11:0] disp_bcd;
  logic [1:0]  disp_cnt;
  logic        err;

  typedef struct { int val; int cyc; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic prev_vld = 1'b0;

  key_entry_ctrl #(.MAX_DIGITS(3), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst_n(rst_n), .key_num(key_num), .key_vld(key_vld),
    .dout(dout), .dout_vld(dout_vld), .disp_bcd(disp_bcd),
    .disp_cnt(disp_cnt), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every dout_vld pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_vld) begin
        if (prev_vld) chk("vld_back_to_back", 1, 0);
        if (sb.size() == 0) begin
          chk("unexpected_vld", int'(dout), -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("dout", int'(dout), e.val);
          chk("vld_latency_cycle", cyc, e.cyc);
        end
      end
      prev_vld = dout_vld;
    end else begin
      prev_vld = 1'b0;
    end
  end

  // Called at a negedge; leaves at the negedge two cycles later
  task automatic press(input logic [3:0] k);
    key_num = k;
    key_vld = 1'b1;
    @(negedge clk);
    key_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic enter_ok(input int val);
    exp_t e;
    e.val = val;
    e.cyc = cyc + 2;
    sb.push_back(e);
    press(4'hE);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dout", int'(dout), 0);
    chk("rst_vld", int'(dout_vld), 0);
    chk("rst_bcd", int'(disp_bcd), 0);
    chk("rst_cnt", int'(disp_cnt), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1,2,3,E -> 123
    press(4'h1); press(4'h2); press(4'h3);
    chk("bcd_123", int'(disp_bcd), 'h123);
    chk("cnt_3", int'(disp_cnt), 3);
    enter_ok(123);
    chk("cnt_after_commit", int'(disp_cnt), 0);

    // 5,1,2,E -> overflow
    press(4'h5); press(4'h1); press(4'h2);
    press(4'hE);
    chk("ovf_err", int'(err), 1);
    chk("ovf_dout_held", int'(dout), 123);
    chk("ovf_bcd_kept", int'(disp_bcd), 'h512);
    press(4'h4); press(4'hB); press(4'hE);
    chk("err_ignores_keys", int'(disp_bcd), 'h512);
    chk("err_still_set", int'(err), 1);
    press(4'hA);
    chk("clr_err", int'(err), 0);
    chk("clr_cnt", int'(disp_cnt), 0);

    // 4,7,B,9,E -> 49
    press(4'h4); press(4'h7); press(4'hB);
    chk("bs_bcd", int'(disp_bcd), 'h004);
    chk("bs_cnt", int'(disp_cnt), 1);
    press(4'h9);
    enter_ok(49);

    // 1,2,3,4 -> fourth digit ignored; commit, then E in IDLE gives no pulse
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("full_bcd", int'(disp_bcd), 'h123);
    chk("full_cnt", int'(disp_cnt), 3);
    enter_ok(123);
    press(4'hE);
    press(4'hC); press(4'hB);
    chk("idle_cnt", int'(disp_cnt), 0);

    // backspace to IDLE, clear in ENTRY, ignored codes
    press(4'h5); press(4'hB);
    chk("bs_to_idle_cnt", int'(disp_cnt), 0);
    press(4'hE);
    press(4'h3); press(4'hD); press(4'hF);
    chk("ignored_codes", int'(disp_bcd), 'h003);
    press(4'hA);
    chk("clr_entry_bcd", int'(disp_bcd), 0);

    // leading zeros
    press(4'h0); press(4'h0); press(4'h7);
    chk("lead0_cnt", int'(disp_cnt), 3);
    enter_ok(7);

    // 5,1,1,E with key 8 in the COMMIT cycle
    press(4'h5); press(4'h1); press(4'h1);
    begin
      exp_t e;
      e.val = 511;
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
    key_num = 4'hE; key_vld = 1'b1;
    @(negedge clk);
    key_num = 4'h8;
    @(negedge clk);
    key_vld = 1'b0;
    chk("commit_drop_cnt", int'(disp_cnt), 0);
    @(negedge clk);
    chk("commit_drop_cnt2", int'(disp_cnt), 0);
    chk("dout_511_held", int'(dout), 511);

    // asynchronous reset mid-entry
    press(4'h6); press(4'h6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", int'(disp_cnt), 0);
    chk("arst_bcd", int'(disp_bcd), 0);
    chk("arst_dout", int'(dout), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    press(4'h2);
    enter_ok(2);

`ifdef KEY_TIMEOUT_EN
    press(4'h9);
    repeat (18) @(negedge clk);
    chk("to_before", int'(disp_cnt), 1);
    @(negedge clk);
    chk("to_expired", int'(disp_cnt), 0);
    press(4'h9);
    repeat (18) @(negedge clk);
    press(4'h3);
    chk("to_key_wins_bcd", int'(disp_bcd), 'h093);
    chk("to_key_wins_cnt", int'(disp_cnt), 2);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
